// File: rtl/uart_rx_packet_parser.sv
// Decodes SOF/LEN/payload/CHK frames from a UART byte stream and releases a payload
// only after its checksum passes; bad, truncated or oversize frames raise one-cycle pulses.
module uart_rx_packet_parser #(
  parameter int         MAX_LEN = 16,
  parameter logic [7:0] SOF     = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_eop,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  input  logic       out_ready,
  output logic       pkt_ok,
  output logic       err_chk,
  output logic       err_len,
  output logic       err_abort,
  output logic       overrun,
  output logic       busy
);

  localparam int IW = $clog2(MAX_LEN) + 1;
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CHK, S_SEND} state_t;

  state_t        state_q, state_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    sum_q, sum_d;
  logic [IW-1:0] wr_idx_q, wr_idx_d;
  logic [IW-1:0] rd_idx_q, rd_idx_d;
  logic          pkt_ok_q, pkt_ok_d;
  logic          err_chk_q, err_chk_d;
  logic          err_len_q, err_len_d;
  logic          err_abort_q, err_abort_d;
  logic          overrun_q, overrun_d;
  logic          busy_q, busy_d;

  logic [7:0]    buf_q [MAX_LEN];
  logic          buf_we;
  logic [7:0]    len_m1;
  logic [7:0]    chk_sum;
  logic          wr_at_end;
  logic          rd_at_end;

  assign len_m1    = len_q - 8'd1;
  assign chk_sum   = sum_q + rx_data;
  assign wr_at_end = ({{(16-IW){1'b0}}, wr_idx_q} == {8'd0, len_m1});
  assign rd_at_end = ({{(16-IW){1'b0}}, rd_idx_q} == {8'd0, len_m1});

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    sum_d       = sum_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    pkt_ok_d    = 1'b0;
    err_chk_d   = 1'b0;
    err_len_d   = 1'b0;
    err_abort_d = 1'b0;
    overrun_d   = 1'b0;
    buf_we      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rx_valid && rx_data == SOF) state_d = S_LEN;
      end
      S_LEN: begin
        if (rx_valid) begin
          if (rx_data == 8'd0 || {24'd0, rx_data} > 32'(MAX_LEN)) begin
            err_len_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            len_d    = rx_data;
            sum_d    = rx_data;
            wr_idx_d = '0;
            state_d  = S_PAYLOAD;
          end
        end else if (rx_eop) begin
          err_abort_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_PAYLOAD: begin
        if (rx_valid) begin
          buf_we   = 1'b1;
          sum_d    = chk_sum;
          wr_idx_d = wr_idx_q + 1'b1;
          if (wr_at_end) state_d = S_CHK;
        end else if (rx_eop) begin
          err_abort_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_CHK: begin
        if (rx_valid) begin
          if (chk_sum == 8'd0) begin
            pkt_ok_d = 1'b1;
            rd_idx_d = '0;
            state_d  = S_SEND;
          end else begin
            err_chk_d = 1'b1;
            state_d   = S_IDLE;
          end
        end else if (rx_eop) begin
          err_abort_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_SEND: begin
        // No input-side buffering: anything arriving while draining is lost.
        overrun_d = rx_valid;
        if (out_ready) begin
          rd_idx_d = rd_idx_q + 1'b1;
          if (rd_at_end) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      sum_q       <= '0;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      pkt_ok_q    <= 1'b0;
      err_chk_q   <= 1'b0;
      err_len_q   <= 1'b0;
      err_abort_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      sum_q       <= sum_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      pkt_ok_q    <= pkt_ok_d;
      err_chk_q   <= err_chk_d;
      err_len_q   <= err_len_d;
      err_abort_q <= err_abort_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  // Payload storage needs no reset; it is only read in SEND after a full frame was written.
  always_ff @(posedge clk) begin
    if (buf_we) buf_q[wr_idx_q[AW-1:0]] <= rx_data;
  end

  assign out_valid = (state_q == S_SEND);
  assign out_data  = out_valid ? buf_q[rd_idx_q[AW-1:0]] : 8'd0;
  assign out_last  = out_valid && rd_at_end;
  assign pkt_ok    = pkt_ok_q;
  assign err_chk   = err_chk_q;
  assign err_len   = err_len_q;
  assign err_abort = err_abort_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_packet_parser.sv
// Bench for uart_rx_packet_parser: queue-based frame model checked every cycle,
// directed frames with literal expectations, then randomized frames and back-pressure.
module tb_uart_rx_packet_parser;

  localparam int         MAX_LEN = 16;
  localparam logic [7:0] SOF     = 8'hA5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       rx_eop = 1'b0;
  logic       out_ready = 1'b1;
  logic       out_valid, out_last, pkt_ok, err_chk, err_len, err_abort, overrun, busy;
  logic [7:0] out_data;

  always #5 clk = ~clk;

  uart_rx_packet_parser #(.MAX_LEN(MAX_LEN), .SOF(SOF)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data), .rx_eop(rx_eop),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .pkt_ok(pkt_ok), .err_chk(err_chk), .err_len(err_len), .err_abort(err_abort),
    .overrun(overrun), .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bytes of the frame in progress, and the payload still owed downstream.
  logic [7:0] m_frame[$];
  logic [7:0] m_out[$];
  bit         m_in_frame = 0;
  bit         e_pkt = 0, e_chk = 0, e_len = 0, e_abort = 0, e_ovr = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_frame.delete();
      m_out.delete();
      m_in_frame = 0;
      e_pkt = 0; e_chk = 0; e_len = 0; e_abort = 0; e_ovr = 0;
    end else begin
      e_pkt = 0; e_chk = 0; e_len = 0; e_abort = 0; e_ovr = 0;
      if (m_out.size() != 0) begin
        if (rx_valid) e_ovr = 1;
        if (out_ready) void'(m_out.pop_front());
      end else if (m_in_frame) begin
        if (rx_valid) begin
          m_frame.push_back(rx_data);
          if (m_frame.size() == 1) begin
            if (rx_data == 0 || rx_data > MAX_LEN) begin
              e_len = 1;
              m_in_frame = 0;
            end
          end else if (m_frame.size() == int'(m_frame[0]) + 2) begin
            int s;
            s = 0;
            foreach (m_frame[i]) s += m_frame[i];
            if (s % 256 == 0) begin
              e_pkt = 1;
              for (int i = 1; i < m_frame.size() - 1; i++) m_out.push_back(m_frame[i]);
            end else begin
              e_chk = 1;
            end
            m_in_frame = 0;
          end
        end else if (rx_eop) begin
          e_abort = 1;
          m_in_frame = 0;
        end
      end else if (rx_valid && rx_data == SOF) begin
        m_in_frame = 1;
        m_frame.delete();
      end
    end
  end

  bit checking = 0;

  always @(negedge clk) begin
    if (checking) begin
      chk("out_valid", out_valid, m_out.size() != 0);
      if (m_out.size() != 0) begin
        chk("out_data", out_data, m_out[0]);
        chk("out_last", out_last, m_out.size() == 1);
      end
      chk("pkt_ok", pkt_ok, e_pkt);
      chk("err_chk", err_chk, e_chk);
      chk("err_len", err_len, e_len);
      chk("err_abort", err_abort, e_abort);
      chk("overrun", overrun, e_ovr);
      chk("busy", busy, m_in_frame || m_out.size() != 0);
    end
  end

  // Record what the DUT actually delivered, for the literal expectations below.
  logic [7:0] got_d[$];
  logic       got_l[$];
  logic [7:0] exp_q[$];
  int cnt_pkt = 0, cnt_chk = 0, cnt_len = 0, cnt_abort = 0, cnt_ovr = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        got_d.push_back(out_data);
        got_l.push_back(out_last);
      end
      cnt_pkt   += int'(pkt_ok);
      cnt_chk   += int'(err_chk);
      cnt_len   += int'(err_len);
      cnt_abort += int'(err_abort);
      cnt_ovr   += int'(overrun);
    end
  end

  bit rand_rdy = 0;
  bit rand_eop = 0;
  int rand_gap = 0;

  task automatic cycle();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 2) != 0);
  endtask

  task automatic put(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    rx_eop   = rand_eop && ($urandom_range(0, 7) == 0);
    cycle();
    rx_valid = 1'b0;
    rx_eop   = 1'b0;
    if (rand_gap > 0) repeat ($urandom_range(0, rand_gap)) cycle();
  endtask

  task automatic eop();
    rx_eop = 1'b1;
    cycle();
    rx_eop = 1'b0;
  endtask

  task automatic wait_idle(input bit noise);
    int k;
    logic [7:0] b;
    cycle();
    cycle();
    k = 0;
    while (busy && k < 400) begin
      if (noise && $urandom_range(0, 3) == 0) begin
        b = 8'($urandom);
        if (b == SOF) b = 8'h00;
        rx_valid = 1'b1;
        rx_data  = b;
      end
      cycle();
      rx_valid = 1'b0;
      k++;
    end
    cycle();
    chk("idle_timeout", k >= 400, 0);
  endtask

  task automatic check_got(input string name);
    chk({name, "_count"}, got_d.size(), exp_q.size());
    if (got_d.size() == exp_q.size()) begin
      foreach (exp_q[i]) begin
        chk({name, "_data"}, got_d[i], exp_q[i]);
        chk({name, "_last"}, got_l[i], i == exp_q.size() - 1);
      end
    end
    got_d.delete();
    got_l.delete();
    exp_q.delete();
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_out_valid"}, out_valid, 0);
    chk({name, "_out_data"}, out_data, 0);
    chk({name, "_out_last"}, out_last, 0);
    chk({name, "_pkt_ok"}, pkt_ok, 0);
    chk({name, "_err_chk"}, err_chk, 0);
    chk({name, "_err_len"}, err_len, 0);
    chk({name, "_err_abort"}, err_abort, 0);
    chk({name, "_overrun"}, overrun, 0);
    chk({name, "_busy"}, busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    #2 rst_n = 1'b0;
    #1 chk_all_zero("reset");
    cycle();
    cycle();
    rst_n = 1'b1;
    checking = 1;
    cycle();

    // Noise then a good frame
    put(8'h00); put(8'hFF); put(8'h12);
    c = cnt_pkt;
    put(8'hA5); put(8'h03); put(8'h11); put(8'h22); put(8'h33); put(8'h97);
    wait_idle(0);
    chk("good_pkt_ok", cnt_pkt - c, 1);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    check_got("good");
    chk("good_busy_after", busy, 0);

    // Bad checksum, then a good frame
    c = cnt_chk;
    put(8'hA5); put(8'h03); put(8'h11); put(8'h22); put(8'h33); put(8'h98);
    wait_idle(0);
    chk("badchk_err", cnt_chk - c, 1);
    check_got("badchk");
    put(8'hA5); put(8'h02); put(8'h10); put(8'h20); put(8'hCE);
    wait_idle(0);
    exp_q.push_back(8'h10); exp_q.push_back(8'h20);
    check_got("after_badchk");

    // Length bounds
    c = cnt_len;
    put(8'hA5); put(8'h00);
    wait_idle(0);
    chk("len_zero", cnt_len - c, 1);
    c = cnt_len;
    put(8'hA5); put(8'h11);
    wait_idle(0);
    chk("len_17", cnt_len - c, 1);
    c = cnt_pkt;
    put(8'hA5); put(8'h10);
    for (int i = 1; i <= 16; i++) begin
      put(8'(i));
      exp_q.push_back(8'(i));
    end
    put(8'h68);
    wait_idle(0);
    chk("len_16_pkt_ok", cnt_pkt - c, 1);
    check_got("len_16");

    // Abort mid-payload, then a one-byte frame whose payload is the SOF-like 5A then CHK A5
    c = cnt_abort;
    put(8'hA5); put(8'h03); put(8'h11);
    eop();
    chk("abort_busy", busy, 0);
    cycle();
    chk("abort_err", cnt_abort - c, 1);
    put(8'hA5); put(8'h01); put(8'h5A); put(8'hA5);
    wait_idle(0);
    exp_q.push_back(8'h5A);
    check_got("after_abort");

    // Back-pressure with overrun bytes
    out_ready = 1'b0;
    c = cnt_ovr;
    put(8'hA5); put(8'h03); put(8'h11); put(8'h22); put(8'h33); put(8'h97);
    put(8'hA5); cycle(); put(8'h01); cycle(); put(8'h77);
    repeat (5) cycle();
    chk("bp_overrun", cnt_ovr - c, 3);
    chk("bp_no_handshake", got_d.size(), 0);
    chk("bp_valid", out_valid, 1);
    chk("bp_data", out_data, 8'h11);
    chk("bp_last", out_last, 0);
    out_ready = 1'b1;
    wait_idle(0);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    check_got("bp_drain");

    // Reset mid-SEND
    out_ready = 1'b0;
    put(8'hA5); put(8'h01); put(8'h42); put(8'hBD);
    cycle();
    chk("pre_rst_send_valid", out_valid, 1);
    rst_n = 1'b0;
    #1 chk_all_zero("rst_send");
    cycle();
    rst_n = 1'b1;
    out_ready = 1'b1;
    cycle();
    got_d.delete(); got_l.delete();

    // Reset mid-PAYLOAD, then a good frame
    put(8'hA5); put(8'h04); put(8'h01); put(8'h02);
    rst_n = 1'b0;
    #1 chk_all_zero("rst_payload");
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();
    put(8'hA5); put(8'h02); put(8'h10); put(8'h20); put(8'hCE);
    wait_idle(0);
    exp_q.push_back(8'h10); exp_q.push_back(8'h20);
    check_got("after_rst");

    // Randomized frames against the model
    rand_rdy = 1;
    rand_eop = 1;
    rand_gap = 2;
    for (int f = 0; f < 60; f++) begin
      int kind, len, s, n;
      logic [7:0] b;
      kind = $urandom_range(0, 5);
      if (kind == 3) begin
        put(SOF);
        put(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)));
      end else begin
        len = $urandom_range(1, MAX_LEN);
        put(SOF);
        put(8'(len));
        s = len;
        n = (kind == 4) ? $urandom_range(0, len) : len;
        for (int i = 0; i < n; i++) begin
          b = 8'($urandom);
          put(b);
          s += b;
        end
        if (kind == 4) begin
          eop();
        end else begin
          b = 8'(256 - (s % 256));
          if (kind == 2) b = b + 8'($urandom_range(1, 255));
          put(b);
        end
      end
      wait_idle(1);
    end
    rand_rdy = 0;
    out_ready = 1'b1;
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_packet_parser.md
# uart_rx_packet_parser

Frame decoder that sits directly downstream of the UART receiver. It consumes the receiver's byte strobe, data byte and end-of-packet pulse, and recognises framed command packets of the form SOF, LEN, payload, CHK. Each packet's payload is buffered internally and released on a valid/ready stream only after the checksum passes. Bad, truncated or over-length frames are dropped and reported through one-cycle error pulses.

## Interface
- MAX_LEN, 16, maximum payload length in bytes; legal range 1..255.
- SOF, 8'hA5, start-of-frame byte value.
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rx_valid  input  1  one-cycle byte strobe from the receiver's data-ready output.
- rx_data  input  8  received byte; valid only when rx_valid=1.
- rx_eop  input  1  one-cycle idle-gap pulse from the receiver's end-of-packet output.
- out_valid  output  1  payload byte available.
- out_data  output  8  payload byte.
- out_last  output  1  marks the final payload byte; qualified by out_valid.
- out_ready  input  1  downstream accepts the byte when out_valid=1 and out_ready=1.
- pkt_ok  output  1  one-cycle pulse: checksum passed.
- err_chk  output  1  one-cycle pulse: checksum mismatch.
- err_len  output  1  one-cycle pulse: LEN=0 or LEN>MAX_LEN.
- err_abort  output  1  one-cycle pulse: rx_eop arrived mid-frame.
- overrun  output  1  one-cycle pulse: a byte was dropped because the block was in SEND.
- busy  output  1  state is not IDLE.

## Operation
- States: IDLE, LEN, PAYLOAD, CHK, SEND.
- Internal storage:
  - buffer: MAX_LEN x 8 bits.
  - len: 8 bits.
  - sum: 8 bits, modulo 256.
  - wr_idx and rd_idx: each clog2(MAX_LEN)+1 bits.
- IDLE:
  - rx_valid with rx_data==SOF moves to LEN.
  - All other bytes are silently ignored.
- LEN, on rx_valid:
  - rx_data==0 or rx_data>MAX_LEN: pulse err_len, go to IDLE.
  - Otherwise: len=rx_data, sum=rx_data, wr_idx=0, go to PAYLOAD.
- PAYLOAD, on rx_valid:
  - buffer[wr_idx]=rx_data, sum=sum+rx_data, wr_idx increments.
  - When the byte just written is index len-1, go to CHK.
- CHK, on rx_valid:
  - (sum+rx_data) mod 256 == 0: pulse pkt_ok, rd_idx=0, go to SEND.
  - Otherwise: pulse err_chk, go to IDLE.
  - CHK is chosen so that LEN + payload + CHK sums to 0 mod 256.
- Abort: rx_eop in LEN, PAYLOAD or CHK with rx_valid=0 in the same cycle pulses err_abort and returns to IDLE.
- Simultaneous events: if rx_valid and rx_eop coincide, the byte is processed and rx_eop is ignored.
- rx_eop in IDLE or SEND has no effect.
- SEND:
  - out_valid=1, out_data=buffer[rd_idx], out_last=(rd_idx==len-1).
  - Each handshake increments rd_idx.
  - The handshake on the last byte returns to IDLE.
- rx_valid during SEND (including a SOF byte) pulses overrun and the byte is discarded; no input-side buffering.
- A SOF byte seen in LEN or PAYLOAD is treated as data; there is no resynchronisation inside a frame.

## Timing
- Reset values: every output is 0, state=IDLE, and all indices and sum are 0.
- Reset takes effect asynchronously. Assertion mid-SEND drops out_valid immediately, and the buffered payload is discarded.
- pkt_ok, err_chk, err_len, err_abort and overrun are registered. Each is high for exactly the one cycle after the causing input cycle.
- out_valid rises in the cycle after the CHK byte's rx_valid cycle, the same cycle as pkt_ok.
- Throughput: one byte per cycle when out_ready is held at 1; a LEN-byte payload drains in LEN cycles.
- While out_valid=1 and out_ready=0: out_data and out_last hold stable and out_valid stays high.
- After the last byte's handshake, out_valid is 0 in the next cycle and a SOF in that cycle is accepted.
- At most one error or status pulse fires per cycle, except overrun, which fires only in SEND.
- busy is registered and equals (state!=IDLE).

## Test plan
- Good frame: A5 03 11 22 33 97 -> pkt_ok pulse; out_data 11, 22, 33 on successive handshakes; out_last only on 33; busy returns to 0.
- Bad checksum: A5 03 11 22 33 98 -> err_chk pulse; out_valid never rises; a following good frame is decoded correctly.
- Length bounds:
  - A5 00 -> err_len.
  - A5 11 (17, with MAX_LEN=16) -> err_len.
  - A5 10 followed by 16 bytes and the correct CHK -> pkt_ok and 16 bytes out with out_last on the 16th.
- Abort: A5 03 11, then rx_eop -> err_abort and IDLE; next frame A5 01 5A A5 -> pkt_ok, out_data 5A with out_last=1.
- Back-pressure:
  - out_ready held 0 for 10 cycles during SEND while 3 bytes arrive -> 3 overrun pulses; out_data stable at the first byte.
  - out_ready then released -> full payload drained intact.
- Reset and noise:
  - Garbage bytes 00 FF 12 before SOF -> ignored.
  - rst_n pulsed low mid-PAYLOAD -> all outputs 0 immediately; the next complete frame decodes normally.
